// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// Pure combinational functions only; no state and no latency of their own.
package arb_pkg;

    localparam int MAX_N  = 8;
    localparam int MAX_IW = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic              vld;
        logic [MAX_IW-1:0] idx;
    } pick_t;

    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IW-1:0] idx);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Winner is the first set request at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0]  req,
                                      input logic [MAX_IW-1:0] ptr,
                                      input int                n);
        pick_t res;
        int    cand;
        res = '0;
        for (int i = 0; i < MAX_N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= n) cand = cand - n;
            if (i < n && !res.vld && req[cand[MAX_IW-1:0]]) begin
                res.vld = 1'b1;
                res.idx = cand[MAX_IW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner select; zero latency, no flow control.
module rr_picker
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] winner_o,
    output logic          any_req_o
);

    pick_t pick;

    always_comb begin
        pick      = rr_pick(MAX_N'(req_i), MAX_IW'(ptr_i), N);
        winner_o  = IW'(pick.idx);
        any_req_o = pick.vld;
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter loading one winner's data into a shared register, then holding it HOLD_CYC cycles.
// Grant/Q appear one edge after REQ is sampled; REQ is ignored while holding, requesters simply wait.
module dff_share_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int W        = 8,
    parameter  int HOLD_CYC = 2,
    localparam int IW       = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [N-1:0]  REQ,
    input  logic [N*W-1:0] DIN,
    input  logic          CLR,
    output logic [N-1:0]  GNT,
    output logic [W-1:0]  Q,
    output logic          Q_VALID,
    output logic [IW-1:0] OWNER,
    output logic          BUSY
);

    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [W-1:0]  q_q, q_d;
    logic          qv_q, qv_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          busy_q, busy_d;

    logic [IW-1:0] winner;
    logic          any_req;

    rr_picker #(.N(N)) u_picker (
        .req_i     (REQ),
        .ptr_i     (ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        q_d     = q_q;
        qv_d    = qv_q;
        owner_d = owner_q;
        busy_d  = busy_q;

        // Clear wins over a grant in the same cycle and leaves the pointer alone.
        if (CLR) begin
            q_d     = '0;
            qv_d    = 1'b0;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_d   = N'(onehot(MAX_IW'(winner)));
                        q_d     = DIN[int'(winner)*W +: W];
                        qv_d    = 1'b1;
                        owner_d = winner;
                        ptr_d   = (int'(winner) == N-1) ? '0 : winner + 1'b1;
                        cnt_d   = CW'(HOLD_CYC-1);
                        state_d = ST_HOLD;
                        busy_d  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign GNT     = gnt_q;
    assign Q       = q_q;
    assign Q_VALID = qv_q;
    assign OWNER   = owner_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Randomized + directed bench for dff_share_arbiter; a cycle model predicts outputs into a queue.
module tb_dff_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int HC = 2;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [N-1:0]  REQ = '0;
    logic [N*W-1:0] DIN = '0;
    logic          CLR = 1'b0;
    logic [N-1:0]  GNT;
    logic [W-1:0]  Q;
    logic          Q_VALID;
    logic [1:0]    OWNER;
    logic          BUSY;

    dff_share_arbiter #(.N(N), .W(W), .HOLD_CYC(HC)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .DIN(DIN), .CLR(CLR),
        .GNT(GNT), .Q(Q), .Q_VALID(Q_VALID), .OWNER(OWNER), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [N-1:0] gnt;
        logic [W-1:0] q;
        logic         qv;
        logic [1:0]   owner;
        logic         busy;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: hold_left counts remaining BUSY cycles after a grant.
    int   m_ptr = 0, m_owner = 0, m_hold = 0, m_q = 0;
    bit   m_qv = 0;

    localparam logic [31:0] DIN_BASE = 32'hA3A2A1A0;

    task automatic model_step(input logic rst_n, input logic [N-1:0] req,
                              input logic [N*W-1:0] din, input logic clr);
        exp_t e;
        int   w;
        bit   found;
        e.gnt = '0;
        if (!rst_n) begin
            m_ptr = 0; m_owner = 0; m_hold = 0; m_q = 0; m_qv = 0;
        end else if (clr) begin
            m_q = 0; m_qv = 0; m_hold = 0;
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
        end else if (req != 0) begin
            found = 0;
            w = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found = 1;
                    w = (m_ptr + k) % N;
                end
            end
            e.gnt   = '0;
            e.gnt[w] = 1'b1;
            m_q     = int'((din >> (w*W)) & 32'hFF);
            m_qv    = 1;
            m_owner = w;
            m_ptr   = (w + 1) % N;
            m_hold  = HC;
        end
        e.q     = m_q[W-1:0];
        e.qv    = m_qv;
        e.owner = m_owner[1:0];
        e.busy  = (m_hold > 0);
        expq.push_back(e);
    endtask

    task automatic cyc(input logic rst_n, input logic [N-1:0] req,
                       input logic [N*W-1:0] din, input logic clr);
        @(negedge CLK);
        RST_N = rst_n;
        REQ   = req;
        DIN   = din;
        CLR   = clr;
        model_step(rst_n, req, din, clr);
    endtask

    task automatic cmp(input string name, input int act, input int req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            if (RST_N === 1'b1) begin
                checks++;
                if ($isunknown(REQ)) begin
                    errors++;
                    $display("FAIL req_known: REQ=%b while out of reset", REQ);
                end
            end
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                cmp("gnt",     int'(GNT),     int'(e.gnt));
                cmp("q",       int'(Q),       int'(e.q));
                cmp("q_valid", int'(Q_VALID), int'(e.qv));
                cmp("owner",   int'(OWNER),   int'(e.owner));
                cmp("busy",    int'(BUSY),    int'(e.busy));
            end
        end
    end

    initial begin : stim
        logic [N*W-1:0] d;
        // Reset with all requests pending, then round-robin through every requester.
        cyc(1'b0, 4'b1111, DIN_BASE, 1'b0);
        cyc(1'b0, 4'b1111, DIN_BASE, 1'b0);
        repeat (13) cyc(1'b1, 4'b1111, DIN_BASE, 1'b0);

        // Pointer skip and wrap after granting 0,1,2.
        cyc(1'b0, 4'b0000, DIN_BASE, 1'b0);
        repeat (7) cyc(1'b1, 4'b1111, DIN_BASE, 1'b0);
        repeat (3) cyc(1'b1, 4'b0010, DIN_BASE, 1'b0);
        repeat (3) cyc(1'b1, 4'b1001, DIN_BASE, 1'b0);
        repeat (3) cyc(1'b1, 4'b1111, DIN_BASE, 1'b0);

        // Hold stability: data and requests churn while the value is held.
        repeat (8) cyc(1'b1, 4'($urandom_range(1, 15)), {$urandom()}, 1'b0);

        // Clear colliding with a pending request in IDLE.
        repeat (4) cyc(1'b1, 4'b0000, DIN_BASE, 1'b0);
        cyc(1'b1, 4'b0100, DIN_BASE, 1'b1);
        cyc(1'b1, 4'b0100, DIN_BASE, 1'b0);
        repeat (3) cyc(1'b1, 4'b0000, DIN_BASE, 1'b0);

        // Reset one cycle into HOLD, then resume from pointer 0.
        cyc(1'b1, 4'b0001, DIN_BASE, 1'b0);
        cyc(1'b0, 4'b0110, DIN_BASE, 1'b0);
        cyc(1'b1, 4'b0110, DIN_BASE, 1'b0);
        repeat (3) cyc(1'b1, 4'b0000, DIN_BASE, 1'b0);

        // Random traffic with occasional clear and reset.
        for (int i = 0; i < 3000; i++) begin
            d = {$urandom()};
            cyc(($urandom_range(0, 99) != 0),
                4'($urandom_range(0, 15)),
                d,
                ($urandom_range(0, 19) == 0));
        end

        repeat (2) @(posedge CLK);
        #2;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
- Round-robin arbiter that shares one W-bit storage register among N requesters.
- Each requester presents data and a request. The block picks one winner and loads its data into the shared register. It then holds that value for a programmable number of cycles before the next grant.
- Used in the lab datapath wherever several sources contend for a single latch/register stage.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, data width of each requester and of the shared register
- HOLD_CYC, 2, cycles the loaded value is held before re-arbitration (>=1)
- IW, $clog2(N), width of the owner index (derived localparam)

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  synchronous, active-low reset
- REQ  input  N  per-requester request, level-sensitive
- DIN  input  N*W  packed data; requester i occupies bits [i*W +: W]
- CLR  input  1  synchronous clear of the shared register
- GNT  output  N  one-hot grant, one-cycle pulse, registered
- Q  output  W  shared register contents
- Q_VALID  output  1  Q holds data loaded by a grant
- OWNER  output  IW  index of the last granted requester
- BUSY  output  1  high while in HOLD

Behaviour:
- All state updates on posedge CLK. All outputs are registered.
- Reset (RST_N=0 at an edge) takes priority over everything:
  - GNT=0, Q=0, Q_VALID=0, OWNER=0, BUSY=0
  - round-robin pointer PTR=0, hold counter=0, state=IDLE
- FSM states: IDLE, HOLD.
- IDLE, REQ==0: remain in IDLE, GNT=0.
- IDLE, REQ!=0 and CLR=0: select the winner w.
  - w is the first set REQ bit searching PTR, PTR+1, ..., N-1, 0, ..., PTR-1 (modulo N).
  - At the same edge: GNT=onehot(w), Q=DIN[w], Q_VALID=1, OWNER=w, PTR=(w+1) mod N, counter=HOLD_CYC-1, state=HOLD, BUSY=1.
- Latency: a REQ sampled at edge k produces GNT, Q and OWNER visible after edge k. GNT is high for exactly one cycle.
- HOLD:
  - GNT=0; Q, OWNER and Q_VALID are unchanged; REQ is ignored.
  - If counter==0: state=IDLE, BUSY=0. Otherwise decrement the counter.
  - Minimum grant spacing is therefore HOLD_CYC+1 cycles.
- Requester protocol:
  - A requester keeps REQ high until it sees its GNT bit, then drops REQ.
  - If REQ is still high after GNT, it stays eligible, but round-robin places it last.
- CLR=1 (RST_N=1), in any state:
  - Q=0, Q_VALID=0, GNT=0, state=IDLE, BUSY=0, counter=0.
  - PTR and OWNER are unchanged.
  - CLR overrides a grant in the same cycle: the pending REQ is not granted, and PTR does not advance.
- Wrap-around: when w=N-1, PTR becomes 0.
- Simultaneous requests resolve deterministically by PTR only. No fixed priority beyond that.
- Reset mid-HOLD aborts the hold immediately, with all outputs at reset values.
- A DIN change during HOLD has no effect on Q.
- X on REQ bits is not tolerated. The bench checks REQ is known whenever RST_N=1.

Decomposition:
- Shared package `arb_pkg`:
  - state enum {ST_IDLE, ST_HOLD}
  - function onehot(idx)
  - function rr_pick(req, ptr), returning the winner index and a valid flag
- One natural sub-module: `rr_picker` (combinational, parameter N). Inputs REQ and PTR; outputs winner index and any_req.
- The FSM, counter and shared register live in the top block.

Test Plan:
- Reset: hold RST_N=0 for 2 edges with REQ=4'b1111 -> GNT=0, Q=0, Q_VALID=0, OWNER=0, BUSY=0. Release -> first grant GNT=4'b0001, Q=DIN[0].
- Round-robin fairness: REQ=4'b1111 constant, DIN[i]=8'hA0+i, HOLD_CYC=2 -> grants 0001, 0010, 0100, 1000, 0001, ... spaced exactly 3 cycles apart; Q=A0, A1, A2, A3, A0.
- Pointer skip/wrap: after granting 2, only REQ[1] set -> next GNT=4'b0010, PTR=2; then REQ=4'b1001 -> GNT=4'b1000, PTR wraps to 0.
- Hold stability: during HOLD, toggle DIN[OWNER] and raise other REQs -> Q, OWNER unchanged, GNT=0, BUSY=1 for HOLD_CYC cycles.
- CLR collision: in IDLE, CLR=1 with REQ=4'b0100 -> no GNT, Q=0, Q_VALID=0, PTR unchanged. Next cycle with CLR=0 -> GNT=4'b0100.
- Reset mid-HOLD: RST_N=0 one cycle into HOLD -> BUSY=0, Q=0, PTR=0 next cycle. With REQ=4'b0110 after release -> GNT=4'b0010.
